// File: rtl/evo_xb_port_pad.sv
// Per-port pad stage: muxes PMUX/GPIO drive onto the pads, synchronises pad inputs back to the
// core, detects pin-change events into sticky flags and raises a single port interrupt.
// Optional build macro: EVO_PAD_GLITCH_FILTER_EN adds a per-pin glitch filter whose length is
// set by filt_len_i.
module evo_xb_port_pad #(
   parameter int unsigned DWIDTH      = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_W      = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DWIDTH-1:0]     pmux_dir_i,
   input  logic [DWIDTH-1:0]     pmux_out_i,
   input  logic [DWIDTH-1:0]     pmux_en_i,
   input  logic [DWIDTH-1:0]     gpio_dir_i,
   input  logic [DWIDTH-1:0]     gpio_out_i,
   input  logic [DWIDTH-1:0]     pad_in_i,
   output logic [DWIDTH-1:0]     pad_oe_o,
   output logic [DWIDTH-1:0]     pad_out_o,
   output logic [DWIDTH-1:0]     pin_val_o,
   input  logic [2*DWIDTH-1:0]   int_mode_i,
   input  logic [DWIDTH-1:0]     int_clr_i,
   output logic [DWIDTH-1:0]     int_flag_o,
   output logic                  int_o,
   input  logic [FILT_W-1:0]     filt_len_i
);

   // Startup counter counts one cycle past the synchroniser latency, so that prev has caught
   // up with pin_val before edges are allowed to set flags.
   localparam int unsigned PrimeW = $clog2(SYNC_STAGES + 2);

   logic [DWIDTH-1:0] pad_oe_q, pad_out_q;
   logic [DWIDTH-1:0] sync_q [SYNC_STAGES];
   logic [DWIDTH-1:0] s;
   logic [DWIDTH-1:0] pin_val_q, prev_q;
   logic [DWIDTH-1:0] flag_q;
   logic [DWIDTH-1:0] hit;
   logic [PrimeW-1:0] prime_cnt_q;
   logic              primed_q;

   assign s = sync_q[SYNC_STAGES-1];

   // Output drive: PMUX-owned pins take PMUX dir/out, the rest take GPIO register values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pad_oe_q  <= '0;
         pad_out_q <= '0;
      end else begin
         pad_oe_q  <= (pmux_en_i & pmux_dir_i) | (~pmux_en_i & gpio_dir_i);
         pad_out_q <= (pmux_en_i & pmux_out_i) | (~pmux_en_i & gpio_out_i);
      end
   end

   // Input synchroniser chain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= pad_in_i;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

`ifdef EVO_PAD_GLITCH_FILTER_EN
   logic [FILT_W-1:0] filt_cnt_q [DWIDTH];

   // Glitch filter: a change is accepted only after filt_len_i+1 consecutive differing cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pin_val_q <= '0;
         for (int i = 0; i < DWIDTH; i++) filt_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < DWIDTH; i++) begin
            if (s[i] == pin_val_q[i]) begin
               filt_cnt_q[i] <= '0;
            end else if (filt_cnt_q[i] >= filt_len_i) begin
               pin_val_q[i]  <= s[i];
               filt_cnt_q[i] <= '0;
            end else begin
               filt_cnt_q[i] <= filt_cnt_q[i] + 1'b1;
            end
         end
      end
   end
`else
   logic unused_filt_len;
   assign unused_filt_len = ^filt_len_i;

   // Unfiltered build: pin value is the synchroniser output, one register later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pin_val_q <= '0;
      else          pin_val_q <= s;
   end
`endif

   // Startup suppression: primed rises once reset-time pin levels have settled through prev.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prime_cnt_q <= '0;
         primed_q    <= 1'b0;
      end else if (!primed_q) begin
         if (prime_cnt_q == PrimeW'(SYNC_STAGES + 1)) primed_q <= 1'b1;
         else                                          prime_cnt_q <= prime_cnt_q + 1'b1;
      end
   end

   // Edge qualification per pin: mode bit 0 enables rise, bit 1 enables fall.
   always_comb begin
      hit = '0;
      for (int i = 0; i < DWIDTH; i++) begin
         hit[i] = primed_q &
                  ((int_mode_i[2*i]   & pin_val_q[i] & ~prev_q[i]) |
                   (int_mode_i[2*i+1] & ~pin_val_q[i] & prev_q[i]));
      end
   end

   // Previous pin value and sticky flags; a set wins over a simultaneous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q <= '0;
         flag_q <= '0;
      end else begin
         prev_q <= pin_val_q;
         flag_q <= hit | (flag_q & ~int_clr_i);
      end
   end

   assign pad_oe_o   = pad_oe_q;
   assign pad_out_o  = pad_out_q;
   assign pin_val_o  = pin_val_q;
   assign int_flag_o = flag_q;
   assign int_o      = |flag_q;

endmodule
